// File: rtl/avalon_port_arbiter.sv
// rtl/avalon_port_arbiter.sv - shares one Avalon-MM master port between instruction and data requesters
// Grants one req/ack requester at a time, steers byte lanes, and aborts on misalignment or bus timeout.
module avalon_port_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic        instr_ack,
  output logic [31:0] instr_readdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_writedata,
  output logic        data_ack,
  output logic [31:0] data_readdata,
  output logic        data_err,
  output logic [31:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  output logic [3:0]  av_byteenable,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_ACK = 2'd2} state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic        gnt_data_q, gnt_data_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [31:0] av_address_q, av_address_d;
  logic [31:0] av_writedata_q, av_writedata_d;
  logic        av_read_q, av_read_d;
  logic        av_write_q, av_write_d;
  logic [3:0]  av_byteenable_q, av_byteenable_d;
  logic        instr_ack_q, instr_ack_d;
  logic        instr_err_q, instr_err_d;
  logic        data_ack_q, data_ack_d;
  logic        data_err_q, data_err_d;
  logic [31:0] instr_readdata_q, instr_readdata_d;
  logic [31:0] data_readdata_q, data_readdata_d;

  logic        pick_data;
  logic        data_legal;
  logic        grant_legal;
  logic [31:0] rd_shifted;
  logic [31:0] rd_value;

  always_comb begin
    pick_data = data_req && (!instr_req || (ROUND_ROBIN == 0) || !last_data_q);
    case (data_size)
      2'b00:   data_legal = 1'b1;
      2'b01:   data_legal = !data_address[0];
      2'b10:   data_legal = (data_address[1:0] == 2'b00);
      default: data_legal = 1'b0;
    endcase
    grant_legal = pick_data ? data_legal : (instr_address[1:0] == 2'b00);
    // Read data is right-aligned from the lane the access started on.
    rd_shifted = av_readdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_value = {24'b0, rd_shifted[7:0]};
      2'b01:   rd_value = {16'b0, rd_shifted[15:0]};
      default: rd_value = rd_shifted;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    last_data_d      = last_data_q;
    gnt_data_d       = gnt_data_q;
    off_d            = off_q;
    size_d           = size_q;
    tcnt_d           = tcnt_q;
    av_address_d     = av_address_q;
    av_writedata_d   = av_writedata_q;
    av_read_d        = av_read_q;
    av_write_d       = av_write_q;
    av_byteenable_d  = av_byteenable_q;
    instr_ack_d      = 1'b0;
    instr_err_d      = 1'b0;
    data_ack_d       = 1'b0;
    data_err_d       = 1'b0;
    instr_readdata_d = instr_readdata_q;
    data_readdata_d  = data_readdata_q;

    case (state_q)
      S_IDLE: begin
        if (instr_req || data_req) begin
          last_data_d = pick_data;
          gnt_data_d  = pick_data;
          if (!grant_legal) begin
            state_d     = S_ACK;
            data_ack_d  = pick_data;
            data_err_d  = pick_data;
            instr_ack_d = !pick_data;
            instr_err_d = !pick_data;
          end else begin
            state_d = S_XFER;
            tcnt_d  = 16'd0;
            if (pick_data) begin
              av_address_d = {data_address[31:2], 2'b00};
              av_read_d    = !data_we;
              av_write_d   = data_we;
              off_d        = data_address[1:0];
              size_d       = data_size;
              case (data_size)
                2'b00: begin
                  av_byteenable_d = 4'b0001 << data_address[1:0];
                  av_writedata_d  = {4{data_writedata[7:0]}};
                end
                2'b01: begin
                  av_byteenable_d = 4'b0011 << data_address[1:0];
                  av_writedata_d  = {2{data_writedata[15:0]}};
                end
                default: begin
                  av_byteenable_d = 4'b1111;
                  av_writedata_d  = data_writedata;
                end
              endcase
            end else begin
              av_address_d    = {instr_address[31:2], 2'b00};
              av_read_d       = 1'b1;
              av_write_d      = 1'b0;
              off_d           = 2'b00;
              size_d          = 2'b10;
              av_byteenable_d = 4'b1111;
              av_writedata_d  = 32'd0;
            end
          end
        end
      end
      S_XFER: begin
        if (!av_waitrequest) begin
          if (av_read_q) begin
            if (gnt_data_q) data_readdata_d = rd_value;
            else            instr_readdata_d = rd_value;
          end
          av_read_d       = 1'b0;
          av_write_d      = 1'b0;
          av_byteenable_d = 4'b0000;
          state_d         = S_ACK;
          data_ack_d      = gnt_data_q;
          instr_ack_d     = !gnt_data_q;
        end else if ((TIMEOUT_LIM != 16'd0) && ((tcnt_q + 16'd1) >= TIMEOUT_LIM)) begin
          av_read_d       = 1'b0;
          av_write_d      = 1'b0;
          av_byteenable_d = 4'b0000;
          state_d         = S_ACK;
          data_ack_d      = gnt_data_q;
          data_err_d      = gnt_data_q;
          instr_ack_d     = !gnt_data_q;
          instr_err_d     = !gnt_data_q;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      last_data_q      <= 1'b0;
      gnt_data_q       <= 1'b0;
      off_q            <= 2'b00;
      size_q           <= 2'b00;
      tcnt_q           <= 16'd0;
      av_address_q     <= 32'd0;
      av_writedata_q   <= 32'd0;
      av_read_q        <= 1'b0;
      av_write_q       <= 1'b0;
      av_byteenable_q  <= 4'b0000;
      instr_ack_q      <= 1'b0;
      instr_err_q      <= 1'b0;
      data_ack_q       <= 1'b0;
      data_err_q       <= 1'b0;
      instr_readdata_q <= 32'd0;
      data_readdata_q  <= 32'd0;
    end else begin
      state_q          <= state_d;
      last_data_q      <= last_data_d;
      gnt_data_q       <= gnt_data_d;
      off_q            <= off_d;
      size_q           <= size_d;
      tcnt_q           <= tcnt_d;
      av_address_q     <= av_address_d;
      av_writedata_q   <= av_writedata_d;
      av_read_q        <= av_read_d;
      av_write_q       <= av_write_d;
      av_byteenable_q  <= av_byteenable_d;
      instr_ack_q      <= instr_ack_d;
      instr_err_q      <= instr_err_d;
      data_ack_q       <= data_ack_d;
      data_err_q       <= data_err_d;
      instr_readdata_q <= instr_readdata_d;
      data_readdata_q  <= data_readdata_d;
    end
  end

  assign instr_ack      = instr_ack_q;
  assign instr_err      = instr_err_q;
  assign instr_readdata = instr_readdata_q;
  assign data_ack       = data_ack_q;
  assign data_err       = data_err_q;
  assign data_readdata  = data_readdata_q;
  assign av_address     = av_address_q;
  assign av_read        = av_read_q;
  assign av_write       = av_write_q;
  assign av_writedata   = av_writedata_q;
  assign av_byteenable  = av_byteenable_q;
  assign busy           = (state_q != S_IDLE);

endmodule
